// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port 2bpp framebuffer arbiter between PPU writes and scan-out reads
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   pix_valid/pix_ready             PPU pixel handshake
//   pix_x, pix_y, pix_col           pixel coordinate and 2-bit shade
//   vblank                          PPU vblank level
//   rd_req/rd_addr/rd_gnt           scan-out read request (held until granted)
//   rd_data_valid/rd_data           scan-out read result, one cycle after grant
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata   single-port RAM interface
//   frame_sync                      one-cycle pulse: frame fully written after vblank
//   fifo_level                      write FIFO occupancy
//   oob_cnt                         saturating count of dropped out-of-bounds pixels

module fb_arbiter #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 144,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic [7:0]                    pix_x,
    input  logic [7:0]                    pix_y,
    input  logic [1:0]                    pix_col,
    input  logic                          vblank,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_gnt,
    output logic                          rd_data_valid,
    output logic [1:0]                    rd_data,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [1:0]                    ram_wdata,
    input  logic [1:0]                    ram_rdata,
    output logic                          frame_sync,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    oob_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // FIFO storage and pointers; depth is a power of two so pointers wrap naturally
    logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
    logic [1:0]        q_col  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              pix_oob;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] lin_addr;
    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;

    logic              vblank_q;
    logic              frame_pending;
    logic              vblank_rise;

    assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign pix_ready  = (fifo_level < LVL_W'(FIFO_DEPTH));

    assign accept  = pix_valid && pix_ready;
    assign pix_oob = ({1'b0, pix_x} >= 9'(WIDTH)) || ({1'b0, pix_y} >= 9'(HEIGHT));
    assign push    = accept && !pix_oob;

    // Linear address y*WIDTH + x, computed modulo 2^ADDR_W. The default
    // width of 160 = 128 + 32 maps to two shifts and an add.
    assign x_ext = ADDR_W'(pix_x);
    assign y_ext = ADDR_W'(pix_y);

    always_comb begin
        if (WIDTH == 160) begin
            lin_addr = (y_ext << 7) + (y_ext << 5) + x_ext;
        end else begin
            lin_addr = y_ext * ADDR_W'(WIDTH) + x_ext;
        end
    end

    // Arbitration: a full FIFO always wins so the PPU cannot stall forever;
    // otherwise scan-out reads win over draining the FIFO. Nothing is
    // issued while reset is asserted.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        rd_gnt    = 1'b0;
        pop       = 1'b0;
        if (rst_n) begin
            if (fifo_full || (!rd_req && !fifo_empty)) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = q_addr[rd_ptr];
                ram_wdata = q_col[rd_ptr];
                pop       = 1'b1;
            end else if (rd_req) begin
                ram_en   = 1'b1;
                ram_addr = rd_addr;
                rd_gnt   = 1'b1;
            end
        end
    end

    // FIFO payload has no reset; only pointers and level define contents
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= lin_addr;
            q_col[wr_ptr]  <= pix_col;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_cnt <= '0;
        end else if (accept && pix_oob && (oob_cnt != 8'hff)) begin
            oob_cnt <= oob_cnt + 8'd1;
        end
    end

    // RAM returns data the cycle after a read; the valid just follows the grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= rd_gnt;
        end
    end

    assign rd_data = ram_rdata;

    // Frame completion: a vblank rise arms the pending flag; the pulse fires
    // from the registered flag once the FIFO is empty and nothing is being
    // pushed, so a rise in the same cycle only takes effect next cycle.
    // Further rises while armed are absorbed.
    assign vblank_rise = vblank && !vblank_q;
    assign frame_sync  = frame_pending && fifo_empty && !push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_q      <= 1'b0;
            frame_pending <= 1'b0;
        end else begin
            vblank_q <= vblank;
            if (frame_sync) begin
                frame_pending <= 1'b0;
            end else if (vblank_rise) begin
                frame_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - randomized self-checking bench for fb_arbiter against a queue-based model

module tb_fb_arbiter;

    localparam int W  = 160;
    localparam int H  = 144;
    localparam int D  = 4;
    localparam int AW = 15;

    logic          clk;
    logic          rst_n;
    logic          pix_valid;
    logic          pix_ready;
    logic [7:0]    pix_x;
    logic [7:0]    pix_y;
    logic [1:0]    pix_col;
    logic          vblank;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_data_valid;
    logic [1:0]    rd_data;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [1:0]    ram_wdata;
    logic [1:0]    ram_rdata;
    logic          frame_sync;
    logic [2:0]    fifo_level;
    logic [7:0]    oob_cnt;

    fb_arbiter #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_col(pix_col),
        .vblank(vblank),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .frame_sync(frame_sync), .fifo_level(fifo_level), .oob_cnt(oob_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM driven by the DUT's RAM port
    logic [1:0] tb_ram [1 << AW];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) tb_ram[ram_addr] <= ram_wdata;
            else        ram_rdata <= tb_ram[ram_addr];
        end
    end

    // Reference model: queue of pending writes plus its own picture of memory
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    col;
    } wr_t;

    wr_t        mq[$];
    logic [1:0] mmem [1 << AW];
    int         m_oob;
    bit         m_pend;
    bit         m_vbq;
    bit         m_valid;
    logic [1:0] m_rdata;

    bit last_acc;
    bit last_gnt;
    bit last_fs;

    int n_chk;
    int n_pass;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_oob   = 0;
        m_pend  = 0;
        m_vbq   = 0;
        m_valid = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance model
    task automatic step(input bit v, input int x, input int y, input int c,
                        input bit vb, input bit rq, input int ra);
        int  sz;
        bit  full, wr, rd, acc, oob, push, fs;
        wr_t head;
        wr_t nw;
        @(negedge clk);
        pix_valid = v;
        pix_x     = 8'(x);
        pix_y     = 8'(y);
        pix_col   = 2'(c);
        vblank    = vb;
        rd_req    = rq;
        rd_addr   = AW'(ra);
        #1;
        sz   = mq.size();
        full = (sz == D);
        wr   = full || (!rq && sz > 0);
        rd   = !full && rq;
        acc  = v && !full;
        oob  = (x >= W) || (y >= H);
        push = acc && !oob;
        fs   = m_pend && (sz == 0) && !push;
        if (sz > 0) head = mq[0];

        check_eq("pix_ready", pix_ready, !full);
        check_eq("fifo_level", fifo_level, sz);
        check_eq("ram_en", ram_en, wr || rd);
        if (wr || rd) check_eq("ram_we", ram_we, wr);
        check_eq("rd_gnt", rd_gnt, rd);
        if (wr) begin
            check_eq("wr_addr", ram_addr, head.addr);
            check_eq("wr_data", ram_wdata, head.col);
        end
        if (rd) check_eq("rd_addr_out", ram_addr, ra);
        check_eq("rd_data_valid", rd_data_valid, m_valid);
        if (m_valid) check_eq("rd_data", rd_data, m_rdata);
        check_eq("frame_sync", frame_sync, fs);
        check_eq("oob_cnt", oob_cnt, m_oob);

        if (wr) begin
            head = mq.pop_front();
            mmem[head.addr] = head.col;
        end
        if (push) begin
            nw.addr = AW'(y * W + x);
            nw.col  = 2'(c);
            mq.push_back(nw);
        end
        if (acc && oob && m_oob < 255) m_oob++;
        m_valid = rd;
        if (rd) m_rdata = mmem[ra];
        m_pend  = fs ? 1'b0 : (m_pend | (vb && !m_vbq));
        m_vbq   = vb;
        last_acc = acc;
        last_gnt = rd;
        last_fs  = frame_sync;
        @(posedge clk);
    endtask

    task automatic idle(input int n, input bit vb);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, vb, 0, 0);
    endtask

    // Hold a pixel until it is accepted, bounded
    task automatic push_px(input int x, input int y, input int c,
                           input bit vb, input bit rq, input int ra);
        for (int t = 0; t < 20; t++) begin
            step(1, x, y, c, vb, rq, ra);
            if (last_acc) break;
        end
        if (!last_acc) check_eq("push_timeout", 0, 1);
    endtask

    initial begin
        int  pulses;
        bit  hold;
        bit  vbr;
        int  ha, x, y;

        n_chk = 0;
        n_pass = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            tb_ram[i] = 2'd0;
            mmem[i]   = 2'd0;
        end
        ram_rdata = 2'd0;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_x     = '0;
        pix_y     = '0;
        pix_col   = '0;
        vblank    = 1'b0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_valid", rd_data_valid, 0);
        check_eq("rst_ram_en", ram_en, 0);
        check_eq("rst_fs", frame_sync, 0);
        check_eq("rst_oob", oob_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_ready", pix_ready, 1);

        // Single pixel (3,2) lands at 323 the next cycle
        push_px(3, 2, 2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(1, 0);

        // Held read at 100 while pushing 5 pixels
        for (int i = 0; i < 5; i++) push_px(10 + i, 5, i % 4, 0, 1, 100);
        step(0, 0, 0, 0, 0, 1, 100);
        idle(6, 0);

        // Write col=3 to address 500 (x=20,y=3), then read it back
        push_px(20, 3, 3, 0, 0, 0);
        idle(2, 0);
        step(0, 0, 0, 0, 0, 1, 500);
        step(0, 0, 0, 0, 0, 0, 0);
        check_eq("rd500_data", rd_data, 3);

        // Out-of-bounds pixels and saturation
        push_px(160, 0, 1, 0, 0, 0);
        push_px(0, 144, 1, 0, 0, 0);
        #1;
        check_eq("oob_two", oob_cnt, 2);
        for (int i = 0; i < 300; i++)
            push_px(160 + $urandom_range(0, 95), $urandom_range(0, 255), 0, 0, 0, 0);
        #1;
        check_eq("oob_sat", oob_cnt, 255);

        // vblank rise with 3 queued writes; a second rise before drain
        for (int i = 0; i < 3; i++) push_px(40 + i, 7, 1, 0, 1, 33);
        pulses = 0;
        step(0, 0, 0, 0, 1, 0, 0); pulses += int'(last_fs);
        step(0, 0, 0, 0, 0, 0, 0); pulses += int'(last_fs);
        step(0, 0, 0, 0, 1, 0, 0); pulses += int'(last_fs);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 0, 0);
            pulses += int'(last_fs);
        end
        check_eq("fs_pulses", pulses, 1);
        idle(2, 0);

        // Reset mid-operation: level 3 and a read in flight
        for (int i = 0; i < 3; i++) push_px(60 + i, 9, 2, 0, 1, 7);
        #2;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        rd_req    = 1'b0;
        #1;
        check_eq("mid_rst_level", fifo_level, 0);
        check_eq("mid_rst_valid", rd_data_valid, 0);
        check_eq("mid_rst_ram_en", ram_en, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4, 0);

        // Randomized traffic; reads hold until granted, biased to a small window
        hold = 0;
        vbr  = 0;
        ha   = 0;
        for (int i = 0; i < 2500; i++) begin
            if (!hold && $urandom_range(0, 3) == 0) begin
                hold = 1;
                ha   = $urandom_range(0, 3) * W + $urandom_range(0, 7);
            end
            if ($urandom_range(0, 29) == 0) vbr = !vbr;
            if ($urandom_range(0, 1) == 0) begin
                x = $urandom_range(0, 7);
                y = $urandom_range(0, 3);
            end else begin
                x = $urandom_range(0, 175);
                y = $urandom_range(0, 155);
            end
            step($urandom_range(0, 9) < 6, x, y, $urandom_range(0, 3), vbr, hold, ha);
            if (last_gnt) hold = 0;
        end
        idle(8, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
